// File: rtl/seq_alu.sv
// Register-file execution stage: logic ops finish in 1 cycle, MUL in WIDTH cycles, shifts in n cycles.
// DONE pulses once per result; START is ignored while BUSY (the control unit stalls on it).
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic             START,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             DONE,
    output logic             BUSY
);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SHIFT
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             done_d;

    logic             wr;
    logic [WIDTH-1:0] wr_val;
    logic [CNT_W-1:0] n_raw;
    logic [CNT_W-1:0] n_eff;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] sh_next;

    assign BUSY = (state != S_IDLE);

    always_comb begin
        state_d  = state;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        result_d = RESULT;
        zero_d   = ZERO;
        done_d   = 1'b0;
        wr       = 1'b0;
        wr_val   = '0;
        n_raw    = DATA2[CNT_W-1:0];
        n_eff    = '0;
        acc_sum  = '0;
        sh_next  = '0;

        case (state)
            S_IDLE: begin
                if (START) begin
                    a_d   = DATA1;
                    b_d   = DATA2;
                    sel_d = SELECT;
                    case (SELECT)
                        OP_FWD: begin wr = 1'b1; wr_val = DATA2;         end
                        OP_ADD: begin wr = 1'b1; wr_val = DATA1 + DATA2; end
                        OP_AND: begin wr = 1'b1; wr_val = DATA1 & DATA2; end
                        OP_OR:  begin wr = 1'b1; wr_val = DATA1 | DATA2; end
                        OP_MUL: begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_MUL;
                        end
                        default: begin
                            // Rotates wrap the amount; logical shifts saturate at WIDTH (result 0).
                            if (SELECT == OP_ROR)
                                n_eff = n_raw % W_C;
                            else
                                n_eff = (n_raw > W_C) ? W_C : n_raw;
                            if (n_eff == '0) begin
                                wr     = 1'b1;
                                wr_val = DATA1;
                            end else begin
                                cnt_d   = n_eff;
                                state_d = S_SHIFT;
                            end
                        end
                    endcase
                end
            end

            S_MUL: begin
                acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;
                acc_d   = acc_sum;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == W_C - 1'b1) begin
                    wr      = 1'b1;
                    wr_val  = acc_sum;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            S_SHIFT: begin
                case (sel_q)
                    OP_SLL:  sh_next = a_q << 1;
                    OP_SRL:  sh_next = a_q >> 1;
                    default: sh_next = {a_q[0], a_q[WIDTH-1:1]};
                endcase
                a_d   = sh_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    wr      = 1'b1;
                    wr_val  = sh_next;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (wr) begin
            result_d = wr_val;
            zero_d   = (wr_val == '0);
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            sel_q  <= OP_FWD;
            RESULT <= '0;
            ZERO   <= 1'b1;
            DONE   <= 1'b0;
        end else begin
            state  <= state_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            RESULT <= result_d;
            ZERO   <= zero_d;
            DONE   <= done_d;
        end
    end

endmodule
